// File: rtl/dmem_pkg.sv
// dmem_pkg: access type codes, clear-engine states and size helper shared by
// the dual-port data memory and its load extension unit.
package dmem_pkg;

    localparam logic [3:0] LOAD_BYTE               = 4'h0;
    localparam logic [3:0] LOAD_HALFWORD           = 4'h1;
    localparam logic [3:0] LOAD_WORD               = 4'h2;
    localparam logic [3:0] LOAD_DOUBLEWORD         = 4'h3;
    localparam logic [3:0] LOAD_BYTE_UNSIGNED      = 4'h4;
    localparam logic [3:0] LOAD_HALFWORD_UNSIGNED  = 4'h5;
    localparam logic [3:0] LOAD_WORD_UNSIGNED      = 4'h6;

    localparam logic [3:0] STORE_BYTE              = 4'h8;
    localparam logic [3:0] STORE_HALFWORD          = 4'h9;
    localparam logic [3:0] STORE_WORD              = 4'hA;
    localparam logic [3:0] STORE_DOUBLEWORD        = 4'hB;

    typedef enum logic {
        CLEAR = 1'b0,
        DONE  = 1'b1
    } clear_state_e;

    // Bytes touched by an access type; 0 marks an unknown code.
    function automatic logic [3:0] access_size(input logic [3:0] accType);
        case (accType)
            LOAD_BYTE, LOAD_BYTE_UNSIGNED, STORE_BYTE:             return 4'd1;
            LOAD_HALFWORD, LOAD_HALFWORD_UNSIGNED, STORE_HALFWORD: return 4'd2;
            LOAD_WORD, LOAD_WORD_UNSIGNED, STORE_WORD:             return 4'd4;
            LOAD_DOUBLEWORD, STORE_DOUBLEWORD:                     return 4'd8;
            default:                                               return 4'd0;
        endcase
    endfunction

    function automatic logic is_store_type(input logic [3:0] accType);
        return (accType == STORE_BYTE) || (accType == STORE_HALFWORD) ||
               (accType == STORE_WORD) || (accType == STORE_DOUBLEWORD);
    endfunction

endpackage

// File: rtl/dual_port_data_mem_load_extend.sv
// load_extend: turns the raw little-endian bytes at the access address into
// the XLEN-wide load result, flagging codes that are not legal loads.
module load_extend
    import dmem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [3:0]      accType,
    input  logic [XLEN-1:0] rawData,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    // Extend the low bytes; fill first with the sign (or zero), then overlay.
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (accType)
            LOAD_BYTE: begin
                result       = {XLEN{rawData[7]}};
                result[7:0]  = rawData[7:0];
            end
            LOAD_HALFWORD: begin
                result       = {XLEN{rawData[15]}};
                result[15:0] = rawData[15:0];
            end
            LOAD_WORD: begin
                result       = {XLEN{rawData[31]}};
                result[31:0] = rawData[31:0];
            end
            LOAD_BYTE_UNSIGNED:     result[7:0]  = rawData[7:0];
            LOAD_HALFWORD_UNSIGNED: result[15:0] = rawData[15:0];
            LOAD_WORD_UNSIGNED: begin
                if (XLEN == 64) result[31:0] = rawData[31:0];
                else            illegal      = 1'b1;
            end
            LOAD_DOUBLEWORD: begin
                if (XLEN == 64) result  = rawData;
                else            illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/dual_port_data_mem.sv
// dual_port_data_mem: byte-addressed little-endian data memory with a
// load/store port (P1, core MEM stage) and a load-only port (P2, debug/DMA).
// After reset a clear engine zeroes one word per cycle before either port
// becomes ready. Responses are registered, one cycle after acceptance.
// Optional build macro MISALIGN_TRAP_EN: reject accesses whose address is not
// a multiple of their size instead of performing them byte-wise.
module dual_port_data_mem
    import dmem_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int MEM_BYTES = 1024
) (
    input  logic            clock,
    input  logic            rst,
    output logic            init_done,
    input  logic            p1_req_valid,
    output logic            p1_ready,
    input  logic            p1_we,
    input  logic [3:0]      p1_type,
    input  logic [XLEN-1:0] p1_addr,
    input  logic [XLEN-1:0] p1_wdata,
    output logic            p1_rsp_valid,
    output logic [XLEN-1:0] p1_rdata,
    output logic            p1_fault,
    input  logic            p2_req_valid,
    output logic            p2_ready,
    input  logic [3:0]      p2_type,
    input  logic [XLEN-1:0] p2_addr,
    output logic            p2_rsp_valid,
    output logic [XLEN-1:0] p2_rdata,
    output logic            p2_fault
);

    localparam int ADDR_W = $clog2(MEM_BYTES);
    localparam int NB     = XLEN / 8;
    localparam int WORDS  = MEM_BYTES / NB;
    localparam int PTR_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

    clear_state_e   state;
    logic [PTR_W-1:0] clearPtr;
    logic [7:0]     mem [MEM_BYTES];
    logic           initDone;

    logic [1:0]                  accept;
    logic [1:0]                  typeOk;
    logic [1:0]                  misalign;
    logic [1:0]                  reqOk;
    logic [1:0]                  isLoad;
    logic [1:0][3:0]             reqType;
    logic [1:0][ADDR_W-1:0]      reqAddr;
    logic [1:0][XLEN-1:0]        rawData;
    logic [1:0][XLEN-1:0]        extData;
    logic [1:0]                  extIllegal;
    logic [1:0]                  rspValid;
    logic [1:0]                  rspFault;
    logic [1:0][XLEN-1:0]        rspData;
    logic [3:0]                  p1Size;
    logic [ADDR_W-1:0]           clearBase;
    logic                        storeEn;
    logic                        unusedAddrBits;

    assign initDone  = (state == DONE);
    assign init_done = initDone;
    assign p1_ready  = initDone;
    assign p2_ready  = initDone;

    assign reqType[0] = p1_type;
    assign reqType[1] = p2_type;
    assign reqAddr[0] = p1_addr[ADDR_W-1:0];
    assign reqAddr[1] = p2_addr[ADDR_W-1:0];
    assign accept     = {p2_req_valid, p1_req_valid} & {2{initDone}};
    assign isLoad     = {1'b1, ~p1_we};
    assign p1Size     = access_size(p1_type);
    assign clearBase  = ADDR_W'(clearPtr) << $clog2(NB);
    assign unusedAddrBits = ^{p1_addr[XLEN-1:ADDR_W], p2_addr[XLEN-1:ADDR_W]};

    // Gather NB bytes from the access address, wrapping at the top of memory.
    always_comb begin
        rawData = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NB; i++) begin
                rawData[p][8*i +: 8] = mem[reqAddr[p] + ADDR_W'(i)];
            end
        end
    end

    load_extend #(.XLEN(XLEN)) u_ext [1:0] (
        .accType (reqType),
        .rawData (rawData),
        .result  (extData),
        .illegal (extIllegal)
    );

    // Decide legality: the request direction must match the type code.
    always_comb begin
        typeOk[0] = p1_we ? (is_store_type(p1_type) &&
                             !(XLEN == 32 && p1_type == STORE_DOUBLEWORD))
                          : !extIllegal[0];
        typeOk[1] = !extIllegal[1];
    end

`ifdef MISALIGN_TRAP_EN
    logic [3:0] p2Size;
    assign p2Size = access_size(p2_type);

    // Any low address bit inside the access size makes it misaligned.
    always_comb begin
        misalign[0] = (reqAddr[0] & (ADDR_W'(p1Size) - ADDR_W'(1))) != '0;
        misalign[1] = (reqAddr[1] & (ADDR_W'(p2Size) - ADDR_W'(1))) != '0;
    end
`else
    assign misalign = '0;
`endif

    assign reqOk   = typeOk & ~misalign;
    assign storeEn = accept[0] & p1_we & reqOk[0];

    // Clear engine: walk every word once after reset, then hold DONE.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            clearPtr <= '0;
        end else if (state == CLEAR) begin
            clearPtr <= clearPtr + PTR_W'(1);
            if (clearPtr == PTR_W'(WORDS - 1)) state <= DONE;
        end
    end

    // Array write: zero fill while clearing, otherwise the low bytes of a P1 store.
    always_ff @(posedge clock) begin
        if (state == CLEAR) begin
            for (int i = 0; i < NB; i++) mem[clearBase + ADDR_W'(i)] <= 8'h00;
        end else if (storeEn) begin
            for (int i = 0; i < NB; i++) begin
                if (4'(i) < p1Size) mem[reqAddr[0] + ADDR_W'(i)] <= p1_wdata[8*i +: 8];
            end
        end
    end

    // Registered responses; faults and store acks carry zero data.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rspValid <= '0;
            rspFault <= '0;
            rspData  <= '0;
        end else begin
            rspValid <= accept;
            rspFault <= accept & ~reqOk;
            for (int p = 0; p < 2; p++) begin
                rspData[p] <= (accept[p] && reqOk[p] && isLoad[p]) ? extData[p] : '0;
            end
        end
    end

    assign p1_rsp_valid = rspValid[0];
    assign p1_fault     = rspFault[0];
    assign p1_rdata     = rspData[0];
    assign p2_rsp_valid = rspValid[1];
    assign p2_fault     = rspFault[1];
    assign p2_rdata     = rspData[1];

endmodule
